// File: rtl/issue_ctrl.sv
// issue_ctrl: one-entry issue register between decode and execute,
// with a register scoreboard and a single outstanding branch lockout.
module issue_ctrl #(
    parameter int NREGS = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op_type,
    input  logic [6:0]       in_op_spec,
    input  logic [31:0]      in_imm,
    input  logic [4:0]       in_rs1_ind,
    input  logic [4:0]       in_rs2_ind,
    input  logic [4:0]       in_rd_ind,
    input  logic             in_uses_rs1,
    input  logic             in_uses_rs2,
    input  logic             in_writes_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_op_type,
    output logic [6:0]       out_op_spec,
    output logic [31:0]      out_imm,
    output logic [4:0]       out_rs1_ind,
    output logic [4:0]       out_rs2_ind,
    output logic [4:0]       out_rd_ind,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd_ind,
    input  logic             br_resolve,
    input  logic             br_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [4:0] OP_ARITH  = 5'd1;
    localparam logic [4:0] OP_MEMORY = 5'd2;
    localparam logic [4:0] OP_BRANCH = 5'd4;
    localparam logic [4:0] OP_JUMP   = 5'd8;

    typedef enum logic {
        RUN,
        BR_WAIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;
    logic [NREGS-1:0] w_wb_clr;
    logic [NREGS-1:0] w_acc_set;

    logic             r_out_valid;
    logic [4:0]       r_op_type;
    logic [6:0]       r_op_spec;
    logic [31:0]      r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_issue_cnt;

    logic w_slot_free;
    logic w_rs1_haz;
    logic w_rs2_haz;
    logic w_waw_haz;
    logic w_hazard;
    logic w_ready;
    logic w_accept;
    logic w_is_ctl;
    logic w_kill;
    logic w_stall;

    // A writeback in the same cycle releases its register immediately.
    assign w_rs1_haz = in_uses_rs1 && (in_rs1_ind != 5'd0)
                    && r_pend[in_rs1_ind]
                    && !(wb_valid && wb_rd_ind == in_rs1_ind);
    assign w_rs2_haz = in_uses_rs2 && (in_rs2_ind != 5'd0)
                    && r_pend[in_rs2_ind]
                    && !(wb_valid && wb_rd_ind == in_rs2_ind);
    assign w_waw_haz = in_writes_rd && (in_rd_ind != 5'd0)
                    && r_pend[in_rd_ind]
                    && !(wb_valid && wb_rd_ind == in_rd_ind);
    assign w_hazard  = w_rs1_haz || w_rs2_haz || w_waw_haz;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_ready     = !rst && (r_state == RUN) && w_slot_free && !w_hazard;
    assign w_accept    = in_valid && w_ready;
    assign w_stall     = in_valid && !w_ready;
    assign w_is_ctl    = (in_op_type == OP_BRANCH) || (in_op_type == OP_JUMP);
    assign w_kill      = (r_state == BR_WAIT) && br_resolve && br_redirect;

    // Set beats clear when the same register retires and is reissued.
    always_comb begin
        w_wb_clr  = '0;
        w_acc_set = '0;
        if (wb_valid && wb_rd_ind != 5'd0) begin
            w_wb_clr[wb_rd_ind] = 1'b1;
        end
        if (w_accept && in_writes_rd && in_rd_ind != 5'd0) begin
            w_acc_set[in_rd_ind] = 1'b1;
        end
        w_pend_nxt = (r_pend & ~w_wb_clr) | w_acc_set;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_accept && w_is_ctl) begin
                    w_state_nxt = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_resolve) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_op_type   <= '0;
            r_op_spec   <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op_type   <= in_op_type;
            r_op_spec   <= in_op_spec;
            r_imm       <= in_imm;
            r_rs1       <= in_rs1_ind;
            r_rs2       <= in_rs2_ind;
            r_rd        <= in_rd_ind;
        end else if (w_kill || (r_out_valid && out_ready)) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (w_stall && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_accept && r_issue_cnt != '1) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
        end
    end

    // A resolve can only target a branch that already left the slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(r_state == RUN && br_resolve));
            assert (!(w_kill && r_out_valid));
        end
    end

    assign in_ready    = w_ready;
    assign out_valid   = r_out_valid;
    assign out_op_type = r_op_type;
    assign out_op_spec = r_op_spec;
    assign out_imm     = r_imm;
    assign out_rs1_ind = r_rs1;
    assign out_rs2_ind = r_rs2;
    assign out_rd_ind  = r_rd;
    assign stall_cnt   = r_stall_cnt;
    assign issue_cnt   = r_issue_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a behavioural model of issue_ctrl.
module tb_issue_ctrl;

    localparam logic [4:0] OP_ARITH  = 5'd1;
    localparam logic [4:0] OP_MEMORY = 5'd2;
    localparam logic [4:0] OP_BRANCH = 5'd4;
    localparam logic [4:0] OP_JUMP   = 5'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op_type;
    logic [6:0]  in_op_spec;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1_ind;
    logic [4:0]  in_rs2_ind;
    logic [4:0]  in_rd_ind;
    logic        in_uses_rs1;
    logic        in_uses_rs2;
    logic        in_writes_rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_op_type;
    logic [6:0]  out_op_spec;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1_ind;
    logic [4:0]  out_rs2_ind;
    logic [4:0]  out_rd_ind;
    logic        wb_valid;
    logic [4:0]  wb_rd_ind;
    logic        br_resolve;
    logic        br_redirect;
    logic [15:0] stall_cnt;
    logic [15:0] issue_cnt;

    always #5 clk = ~clk;

    issue_ctrl #(.NREGS(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_type(in_op_type), .in_op_spec(in_op_spec),
        .in_imm(in_imm),
        .in_rs1_ind(in_rs1_ind), .in_rs2_ind(in_rs2_ind),
        .in_rd_ind(in_rd_ind),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_writes_rd(in_writes_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_type(out_op_type), .out_op_spec(out_op_spec),
        .out_imm(out_imm),
        .out_rs1_ind(out_rs1_ind), .out_rs2_ind(out_rs2_ind),
        .out_rd_ind(out_rd_ind),
        .wb_valid(wb_valid), .wb_rd_ind(wb_rd_ind),
        .br_resolve(br_resolve), .br_redirect(br_redirect),
        .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: set of pending registers, lockout flag, held instruction.
    bit          m_pend[32];
    bit          m_brw;
    bit          m_ov;
    logic [4:0]  m_type;
    logic [6:0]  m_spec;
    logic [31:0] m_imm;
    logic [4:0]  m_rs1;
    logic [4:0]  m_rs2;
    logic [4:0]  m_rd;
    int          m_stall;
    int          m_issue;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input bit en, input logic [4:0] r);
        return en && r != 5'd0 && m_pend[r]
            && !(wb_valid && wb_rd_ind == r);
    endfunction

    function automatic bit m_ready();
        if (rst || m_brw) return 1'b0;
        if (m_ov && !out_ready) return 1'b0;
        return !blocked(in_uses_rs1, in_rs1_ind)
            && !blocked(in_uses_rs2, in_rs2_ind)
            && !blocked(in_writes_rd, in_rd_ind);
    endfunction

    // Compare this cycle's outputs, advance the model, move to next cycle.
    task automatic step();
        bit rdy;
        bit acc;
        #1;
        rdy = m_ready();
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_ov);
        chk("out_op_type", out_op_type, m_type);
        chk("out_op_spec", out_op_spec, m_spec);
        chk("out_imm", out_imm, m_imm);
        chk("out_rs1", out_rs1_ind, m_rs1);
        chk("out_rs2", out_rs2_ind, m_rs2);
        chk("out_rd", out_rd_ind, m_rd);
        chk("issue_cnt", issue_cnt, m_issue);
        chk("stall_cnt", stall_cnt, m_stall);
        acc = in_valid && rdy;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_brw = 0; m_ov = 0;
            m_type = 0; m_spec = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            m_stall = 0; m_issue = 0;
        end else begin
            if (in_valid && !rdy && m_stall < 65535) m_stall++;
            if (wb_valid && wb_rd_ind != 0) m_pend[wb_rd_ind] = 1'b0;
            if (acc) begin
                m_ov = 1; m_type = in_op_type; m_spec = in_op_spec;
                m_imm = in_imm; m_rs1 = in_rs1_ind;
                m_rs2 = in_rs2_ind; m_rd = in_rd_ind;
                if (m_issue < 65535) m_issue++;
                if (in_writes_rd && in_rd_ind != 0) m_pend[in_rd_ind] = 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (m_brw && br_resolve) begin
                m_brw = 0;
                if (br_redirect) m_ov = 0;
            end else if (acc && (in_op_type == OP_BRANCH ||
                                 in_op_type == OP_JUMP)) begin
                m_brw = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; out_ready = 1;
        wb_valid = 0; wb_rd_ind = 0;
        br_resolve = 0; br_redirect = 0;
        in_op_type = 0; in_op_spec = 0; in_imm = 0;
        in_rs1_ind = 0; in_rs2_ind = 0; in_rd_ind = 0;
        in_uses_rs1 = 0; in_uses_rs2 = 0; in_writes_rd = 0;
    endtask

    task automatic put(input logic [4:0] t, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic w,
                       input logic [31:0] imm);
        in_valid = 1; in_op_type = t; in_op_spec = 7'h13;
        in_imm = imm; in_rs1_ind = r1; in_rs2_ind = r2;
        in_rd_ind = rd; in_uses_rs1 = u1; in_uses_rs2 = u2;
        in_writes_rd = w;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        int pl[$];
        int r;
        idle();
        rst = 1;
        @(negedge clk);
        #1 chk("rst_in_ready", in_ready, 0);
        step();
        rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_issue", issue_cnt, 0);
        chk("rst_stall", stall_cnt, 0);

        // back-to-back independent
        do_reset();
        put(OP_ARITH, 0, 0, 1, 1, 0, 1, 1);
        step();
        put(OP_ARITH, 0, 0, 2, 1, 0, 1, 2);
        #1 chk("b2b_ready", in_ready, 1);
        step();
        chk("b2b_ov", out_valid, 1);
        idle();
        step();
        chk("b2b_issue", issue_cnt, 2);
        chk("b2b_stall", stall_cnt, 0);

        // RAW stall with writeback bypass
        do_reset();
        put(OP_ARITH, 1, 2, 3, 1, 1, 1, 0);
        step();
        put(OP_ARITH, 3, 1, 4, 1, 1, 1, 0);
        repeat (3) begin
            #1 chk("raw_hold", in_ready, 0);
            step();
        end
        wb_valid = 1; wb_rd_ind = 3;
        #1 chk("raw_bypass", in_ready, 1);
        step();
        idle();
        step();
        chk("raw_stall", stall_cnt, 3);
        chk("raw_issue", issue_cnt, 2);

        // WAW with same-cycle set-wins
        do_reset();
        put(OP_ARITH, 0, 0, 5, 1, 0, 1, 0);
        step();
        put(OP_ARITH, 0, 0, 5, 1, 0, 1, 0);
        wb_valid = 1; wb_rd_ind = 5;
        #1 chk("waw_bypass", in_ready, 1);
        step();
        wb_valid = 0;
        put(OP_ARITH, 5, 0, 6, 1, 0, 1, 0);
        repeat (2) begin
            #1 chk("waw_keep", in_ready, 0);
            step();
        end
        wb_valid = 1; wb_rd_ind = 5;
        step();
        idle();
        step();
        chk("waw_stall", stall_cnt, 2);
        chk("waw_issue", issue_cnt, 3);

        // backpressure holds the slot
        do_reset();
        out_ready = 0;
        put(OP_ARITH, 0, 0, 1, 1, 0, 1, 32'h7FF);
        step();
        put(OP_ARITH, 0, 0, 2, 1, 0, 1, 32'h1);
        repeat (5) begin
            #1 chk("bp_ready", in_ready, 0);
            chk("bp_imm", out_imm, 32'h7FF);
            step();
        end
        chk("bp_stall", stall_cnt, 5);
        chk("bp_issue", issue_cnt, 1);
        out_ready = 1;
        step();
        chk("bp_issue2", issue_cnt, 2);
        chk("bp_imm2", out_imm, 32'h1);
        idle();
        step();

        // branch lockout
        do_reset();
        put(OP_BRANCH, 1, 2, 0, 1, 1, 0, 32'h10);
        step();
        put(OP_ARITH, 0, 0, 1, 1, 0, 1, 3);
        repeat (5) begin
            #1 chk("br_hold", in_ready, 0);
            step();
        end
        br_resolve = 1;
        #1 chk("br_res_ready", in_ready, 0);
        step();
        br_resolve = 0;
        #1 chk("br_after", in_ready, 1);
        step();
        idle();
        step();
        chk("br_stall", stall_cnt, 6);
        chk("br_issue", issue_cnt, 2);

        // reset during lockout, then x0 is never a hazard
        do_reset();
        put(OP_ARITH, 0, 0, 7, 1, 0, 1, 0);
        step();
        put(OP_JUMP, 0, 0, 0, 0, 0, 0, 4);
        step();
        idle();
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rr_issue", issue_cnt, 0);
        chk("rr_stall", stall_cnt, 0);
        chk("rr_ov", out_valid, 0);
        put(OP_ARITH, 7, 0, 8, 1, 0, 1, 0);
        #1 chk("rr_x7_clear", in_ready, 1);
        step();
        put(OP_ARITH, 0, 0, 0, 1, 0, 1, 0);
        step();
        put(OP_ARITH, 0, 0, 9, 1, 1, 1, 0);
        #1 chk("x0_ready", in_ready, 1);
        step();
        idle();
        step();
        chk("x0_stall", stall_cnt, 0);
        chk("x0_issue", issue_cnt, 3);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 9);
                put(r < 6 ? OP_ARITH : r < 8 ? OP_MEMORY :
                    r == 8 ? OP_BRANCH : OP_JUMP,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom),
                    1'($urandom), 1'($urandom), $urandom);
            end
            pl.delete();
            for (int i = 1; i < 32; i++) if (m_pend[i]) pl.push_back(i);
            if (pl.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_valid = 1;
                wb_rd_ind = 5'(pl[$urandom_range(0, pl.size() - 1)]);
            end else if ($urandom_range(0, 9) == 0) begin
                wb_valid = 1;
                wb_rd_ind = 5'($urandom_range(0, 31));
            end
            if (m_brw && !m_ov && $urandom_range(0, 3) == 0) begin
                br_resolve = 1;
                br_redirect = 1'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
